// File: rtl/axi4_wide_write_order_buffer.sv
// axi4_wide_write_order_buffer
// Buffers the 128-bit AW and W channels between the straddle converter and
// the switch. W beats are released downstream only once their owning AW has
// handshaken on the master side. WLAST is regenerated from AWLEN.
//
// Optional feature: define WLAST_CHECK_EN to store the upstream WLAST and
// flag a sticky ERR_WLAST when it disagrees with the regenerated WLAST.
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W*    upstream AW and W channels (slave side)
//   M_AXI_AW* / M_AXI_W*    downstream AW and W channels (master side)
//   ERR_WLAST               sticky upstream WLAST framing error
// FIFO depths must be powers of two and at least 2.
module axi4_wide_write_order_buffer #(
  parameter int unsigned C_AXI_ID_WIDTH   = 4,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 128,
  parameter int unsigned AW_DEPTH         = 4,
  parameter int unsigned W_DEPTH          = 16,
  parameter int unsigned MAX_OUTSTANDING  = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic                          ERR_WLAST
);

  localparam int unsigned STRB_W     = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned AW_ENTRY_W = C_AXI_ID_WIDTH + C_AXI_ADDR_WIDTH + 8 + 3 + 2;
`ifdef WLAST_CHECK_EN
  localparam int unsigned W_ENTRY_W  = C_AXI_DATA_WIDTH + STRB_W + 1;
`else
  localparam int unsigned W_ENTRY_W  = C_AXI_DATA_WIDTH + STRB_W;
`endif
  localparam int unsigned AW_PTR_W   = $clog2(AW_DEPTH);
  localparam int unsigned AW_CNT_W   = AW_PTR_W + 1;
  localparam int unsigned W_PTR_W    = $clog2(W_DEPTH);
  localparam int unsigned W_CNT_W    = W_PTR_W + 1;
  localparam int unsigned LEN_PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned LEN_CNT_W  = LEN_PTR_W + 1;

  // ---------------------------------------------------------------- AW FIFO
  logic [AW_ENTRY_W-1:0] aw_mem [AW_DEPTH];
  logic [AW_PTR_W-1:0]   aw_wr_ptr, aw_rd_ptr;
  logic [AW_CNT_W-1:0]   aw_count, aw_count_nxt;
  logic                  aw_ready_q, aw_push, aw_pop;
  logic [AW_ENTRY_W-1:0] aw_head;

  // ---------------------------------------------------------------- len FIFO
  logic [7:0]            len_mem [MAX_OUTSTANDING];
  logic [LEN_PTR_W-1:0]  len_wr_ptr, len_rd_ptr;
  logic [LEN_CNT_W-1:0]  len_count, len_count_nxt;
  logic                  len_push, len_pop, len_empty, len_full;
  logic [7:0]            len_head;

  // ---------------------------------------------------------------- W FIFO
  logic [W_ENTRY_W-1:0]  w_mem [W_DEPTH];
  logic [W_PTR_W-1:0]    w_wr_ptr, w_rd_ptr;
  logic [W_CNT_W-1:0]    w_count, w_count_nxt;
  logic                  w_ready_q, w_push, w_pop;
  logic [W_ENTRY_W-1:0]  w_din, w_head;

  logic [7:0]            beat_cnt;

  // AW FIFO control; ready is registered from the next-cycle occupancy
  assign aw_push       = S_AXI_AWVALID & aw_ready_q;
  assign aw_pop        = M_AXI_AWVALID & M_AXI_AWREADY;
  assign aw_count_nxt  = aw_count + AW_CNT_W'(aw_push) - AW_CNT_W'(aw_pop);
  assign aw_head       = aw_mem[aw_rd_ptr];
  assign S_AXI_AWREADY = aw_ready_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < AW_DEPTH; i++) aw_mem[i] <= '0;
      aw_wr_ptr  <= '0;
      aw_rd_ptr  <= '0;
      aw_count   <= '0;
      aw_ready_q <= 1'b0;
    end else begin
      if (aw_push) begin
        aw_mem[aw_wr_ptr] <= {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST};
        aw_wr_ptr         <= aw_wr_ptr + AW_PTR_W'(1);
      end
      if (aw_pop) aw_rd_ptr <= aw_rd_ptr + AW_PTR_W'(1);
      aw_count   <= aw_count_nxt;
      aw_ready_q <= (aw_count_nxt != AW_CNT_W'(AW_DEPTH));
    end
  end

  assign {M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST} = aw_head;
  // An AW is only issued when there is room to remember its length
  assign M_AXI_AWVALID = (aw_count != '0) && !len_full;

  // Len FIFO: one entry per issued AW whose W burst is still incomplete
  assign len_push      = aw_pop;
  assign len_pop       = w_pop & M_AXI_WLAST;
  assign len_count_nxt = len_count + LEN_CNT_W'(len_push) - LEN_CNT_W'(len_pop);
  assign len_empty     = (len_count == '0);
  assign len_full      = (len_count == LEN_CNT_W'(MAX_OUTSTANDING));
  assign len_head      = len_mem[len_rd_ptr];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) len_mem[i] <= '0;
      len_wr_ptr <= '0;
      len_rd_ptr <= '0;
      len_count  <= '0;
    end else begin
      if (len_push) begin
        len_mem[len_wr_ptr] <= M_AXI_AWLEN;
        len_wr_ptr          <= len_wr_ptr + LEN_PTR_W'(1);
      end
      if (len_pop) len_rd_ptr <= len_rd_ptr + LEN_PTR_W'(1);
      len_count <= len_count_nxt;
    end
  end

  // W FIFO control
`ifdef WLAST_CHECK_EN
  assign w_din = {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST};
`else
  assign w_din = {S_AXI_WDATA, S_AXI_WSTRB};
  logic unused_s_wlast;
  assign unused_s_wlast = S_AXI_WLAST;
`endif
  assign w_push       = S_AXI_WVALID & w_ready_q;
  assign w_pop        = M_AXI_WVALID & M_AXI_WREADY;
  assign w_count_nxt  = w_count + W_CNT_W'(w_push) - W_CNT_W'(w_pop);
  assign w_head       = w_mem[w_rd_ptr];
  assign S_AXI_WREADY = w_ready_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < W_DEPTH; i++) w_mem[i] <= '0;
      w_wr_ptr  <= '0;
      w_rd_ptr  <= '0;
      w_count   <= '0;
      w_ready_q <= 1'b0;
    end else begin
      if (w_push) begin
        w_mem[w_wr_ptr] <= w_din;
        w_wr_ptr        <= w_wr_ptr + W_PTR_W'(1);
      end
      if (w_pop) w_rd_ptr <= w_rd_ptr + W_PTR_W'(1);
      w_count   <= w_count_nxt;
      w_ready_q <= (w_count_nxt != W_CNT_W'(W_DEPTH));
    end
  end

  assign M_AXI_WDATA  = w_head[W_ENTRY_W-1 -: C_AXI_DATA_WIDTH];
  assign M_AXI_WSTRB  = w_head[W_ENTRY_W-C_AXI_DATA_WIDTH-1 -: STRB_W];
  // A beat may leave only once some issued AW owns it
  assign M_AXI_WVALID = (w_count != '0) && !len_empty;
  // Framing comes solely from the issued AWLEN; forced low with no owner
  assign M_AXI_WLAST  = !len_empty && (beat_cnt == len_head);

  // Beat position within the current downstream burst
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      beat_cnt <= '0;
    end else if (w_pop) begin
      beat_cnt <= M_AXI_WLAST ? 8'd0 : beat_cnt + 8'd1;
    end
  end

`ifdef WLAST_CHECK_EN
  // Sticky flag: upstream WLAST disagrees with the AWLEN-derived framing
  logic err_q;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_q <= 1'b0;
    end else if (w_pop && (w_head[0] != M_AXI_WLAST)) begin
      err_q <= 1'b1;
    end
  end
  assign ERR_WLAST = err_q;
`else
  assign ERR_WLAST = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_wide_write_order_buffer.sv
// Directed testbench for axi4_wide_write_order_buffer.
// Inputs change and outputs are sampled on the falling edge; handshakes
// seen at a falling edge complete on the following rising edge.
module tb_axi4_wide_write_order_buffer;

  localparam int unsigned IDW = 4;
  localparam int unsigned ADW = 32;
  localparam int unsigned DW  = 128;
  localparam int unsigned SW  = DW / 8;
`ifdef WLAST_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic           ACLK;
  logic           ARESET;
  logic [IDW-1:0] S_AXI_AWID;
  logic [ADW-1:0] S_AXI_AWADDR;
  logic [7:0]     S_AXI_AWLEN;
  logic [2:0]     S_AXI_AWSIZE;
  logic [1:0]     S_AXI_AWBURST;
  logic           S_AXI_AWVALID;
  logic           S_AXI_AWREADY;
  logic [DW-1:0]  S_AXI_WDATA;
  logic [SW-1:0]  S_AXI_WSTRB;
  logic           S_AXI_WLAST;
  logic           S_AXI_WVALID;
  logic           S_AXI_WREADY;
  logic [IDW-1:0] M_AXI_AWID;
  logic [ADW-1:0] M_AXI_AWADDR;
  logic [7:0]     M_AXI_AWLEN;
  logic [2:0]     M_AXI_AWSIZE;
  logic [1:0]     M_AXI_AWBURST;
  logic           M_AXI_AWVALID;
  logic           M_AXI_AWREADY;
  logic [DW-1:0]  M_AXI_WDATA;
  logic [SW-1:0]  M_AXI_WSTRB;
  logic           M_AXI_WLAST;
  logic           M_AXI_WVALID;
  logic           M_AXI_WREADY;
  logic           ERR_WLAST;

  axi4_wide_write_order_buffer dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .ERR_WLAST(ERR_WLAST)
  );

  typedef struct {
    int             cyc;
    logic [IDW-1:0] id;
    logic [ADW-1:0] addr;
    logic [7:0]     len;
  } awrec_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic          err;
  } wrec_t;

  awrec_t maw_q[$];
  wrec_t  mw_q[$];
  int     cyc;
  int     first_wv;
  int     checks;
  int     failures;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Record downstream handshakes that complete on the coming rising edge
  task automatic step();
    awrec_t a;
    wrec_t  w;
    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
      a.cyc = cyc; a.id = M_AXI_AWID; a.addr = M_AXI_AWADDR; a.len = M_AXI_AWLEN;
      maw_q.push_back(a);
    end
    if (M_AXI_WVALID && M_AXI_WREADY) begin
      w.cyc = cyc; w.data = M_AXI_WDATA; w.strb = M_AXI_WSTRB;
      w.last = M_AXI_WLAST; w.err = ERR_WLAST;
      mw_q.push_back(w);
    end
    if (M_AXI_WVALID && first_wv < 0) first_wv = cyc;
    cyc++;
    @(negedge ACLK);
  endtask

  task automatic clear_mon();
    maw_q.delete();
    mw_q.delete();
    cyc      = 0;
    first_wv = -1;
  endtask

  task automatic set_aw(input logic [IDW-1:0] id, input logic [ADW-1:0] addr, input logic [7:0] len);
    S_AXI_AWID    = id;
    S_AXI_AWADDR  = addr;
    S_AXI_AWLEN   = len;
    S_AXI_AWSIZE  = 3'd4;
    S_AXI_AWBURST = 2'b01;
  endtask

  task automatic test_reset();
    ARESET        = 1'b1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    set_aw('0, '0, '0);
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WLAST   = 1'b0;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    checks++; if (S_AXI_AWREADY !== 1'b0) begin failures++; $display("FAIL reset_awready: got %0b want 0", S_AXI_AWREADY); end
    checks++; if (S_AXI_WREADY !== 1'b0) begin failures++; $display("FAIL reset_wready: got %0b want 0", S_AXI_WREADY); end
    checks++; if (M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL reset_awvalid: got %0b want 0", M_AXI_AWVALID); end
    checks++; if (M_AXI_WVALID !== 1'b0) begin failures++; $display("FAIL reset_wvalid: got %0b want 0", M_AXI_WVALID); end
    checks++; if (ERR_WLAST !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b want 0", ERR_WLAST); end
    checks++; if (M_AXI_AWADDR !== 32'h0) begin failures++; $display("FAIL reset_awaddr: got %0h want 0", M_AXI_AWADDR); end
    checks++; if (M_AXI_WDATA !== 128'h0) begin failures++; $display("FAIL reset_wdata: got %0h want 0", M_AXI_WDATA); end
    checks++; if (M_AXI_WLAST !== 1'b0) begin failures++; $display("FAIL reset_wlast: got %0b want 0", M_AXI_WLAST); end
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++; if (S_AXI_AWREADY !== 1'b1) begin failures++; $display("FAIL post_reset_awready: got %0b want 1", S_AXI_AWREADY); end
    checks++; if (S_AXI_WREADY !== 1'b1) begin failures++; $display("FAIL post_reset_wready: got %0b want 1", S_AXI_WREADY); end
  endtask

  // AWLEN=3, AW five cycles ahead of four back-to-back W beats
  task automatic test_single_burst();
    clear_mon();
    set_aw(4'h5, 32'h0000_1000, 8'd3);
    S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      S_AXI_WVALID = 1'b1;
      S_AXI_WDATA  = DW'(32'hA0 + i);
      S_AXI_WSTRB  = 16'h000F << (4 * i);
      S_AXI_WLAST  = (i == 3);
      step();
    end
    S_AXI_WVALID = 1'b0;
    repeat (4) step();
    checks++; if (maw_q.size() !== 1) begin failures++; $display("FAIL single_aw_count: got %0d want 1", maw_q.size()); end
    if (maw_q.size() == 1) begin
      checks++; if (maw_q[0].cyc !== 1) begin failures++; $display("FAIL single_aw_cycle: got %0d want 1", maw_q[0].cyc); end
      checks++; if (maw_q[0].addr !== 32'h1000) begin failures++; $display("FAIL single_aw_addr: got %0h want 1000", maw_q[0].addr); end
      checks++; if (maw_q[0].len !== 8'd3) begin failures++; $display("FAIL single_aw_len: got %0d want 3", maw_q[0].len); end
      checks++; if (maw_q[0].id !== 4'h5) begin failures++; $display("FAIL single_aw_id: got %0h want 5", maw_q[0].id); end
    end
    checks++; if (mw_q.size() !== 4) begin failures++; $display("FAIL single_w_count: got %0d want 4", mw_q.size()); end
    if (mw_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        logic [SW-1:0] es;
        es = 16'h000F << (4 * i);
        checks++; if (mw_q[i].data !== DW'(32'hA0 + i)) begin failures++; $display("FAIL single_w_data[%0d]: got %0h want %0h", i, mw_q[i].data, 32'hA0 + i); end
        checks++; if (mw_q[i].strb !== es) begin failures++; $display("FAIL single_w_strb[%0d]: got %0h want %0h", i, mw_q[i].strb, es); end
        checks++; if (mw_q[i].last !== (i == 3)) begin failures++; $display("FAIL single_w_last[%0d]: got %0b want %0b", i, mw_q[i].last, (i == 3)); end
        checks++; if (mw_q[i].cyc !== 7 + i) begin failures++; $display("FAIL single_w_cycle[%0d]: got %0d want %0d", i, mw_q[i].cyc, 7 + i); end
      end
    end
    checks++; if (ERR_WLAST !== 1'b0) begin failures++; $display("FAIL single_err: got %0b want 0", ERR_WLAST); end
  endtask

  // Two W beats arrive ten cycles before their AW (AWLEN=1)
  task automatic test_w_before_aw();
    clear_mon();
    for (int i = 0; i < 2; i++) begin
      S_AXI_WVALID = 1'b1;
      S_AXI_WDATA  = DW'(32'hB0 + i);
      S_AXI_WSTRB  = '1;
      S_AXI_WLAST  = (i == 1);
      step();
    end
    S_AXI_WVALID = 1'b0;
    repeat (10) step();
    set_aw(4'h2, 32'h0000_2000, 8'd1);
    S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    repeat (6) step();
    checks++; if (maw_q.size() !== 1) begin failures++; $display("FAIL wfirst_aw_count: got %0d want 1", maw_q.size()); end
    if (maw_q.size() == 1) begin
      checks++; if (maw_q[0].cyc !== 13) begin failures++; $display("FAIL wfirst_aw_cycle: got %0d want 13", maw_q[0].cyc); end
    end
    checks++; if (first_wv !== 14) begin failures++; $display("FAIL wfirst_wvalid_cycle: got %0d want 14", first_wv); end
    checks++; if (mw_q.size() !== 2) begin failures++; $display("FAIL wfirst_w_count: got %0d want 2", mw_q.size()); end
    if (mw_q.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (mw_q[i].data !== DW'(32'hB0 + i)) begin failures++; $display("FAIL wfirst_w_data[%0d]: got %0h want %0h", i, mw_q[i].data, 32'hB0 + i); end
        checks++; if (mw_q[i].last !== (i == 1)) begin failures++; $display("FAIL wfirst_w_last[%0d]: got %0b want %0b", i, mw_q[i].last, (i == 1)); end
        checks++; if (mw_q[i].cyc !== 14 + i) begin failures++; $display("FAIL wfirst_w_cycle[%0d]: got %0d want %0d", i, mw_q[i].cyc, 14 + i); end
      end
    end
  endtask

  // Downstream stalls 20 cycles while 16 beats fill the W FIFO
  task automatic test_backpressure();
    int   sent;
    logic hs;
    logic stable_ok;
    clear_mon();
    sent      = 0;
    stable_ok = 1'b1;
    M_AXI_WREADY = 1'b0;
    set_aw(4'h3, 32'h0000_3000, 8'd15);
    S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    for (int c = 0; c < 20; c++) begin
      S_AXI_WVALID = (sent < 16);
      S_AXI_WDATA  = DW'(32'hC0 + sent);
      S_AXI_WSTRB  = '1;
      S_AXI_WLAST  = (sent == 15);
      hs = S_AXI_WVALID && S_AXI_WREADY;
      if (M_AXI_WVALID && (M_AXI_WDATA !== DW'(32'hC0) || M_AXI_WLAST !== 1'b0)) stable_ok = 1'b0;
      step();
      if (hs) sent++;
    end
    S_AXI_WVALID = 1'b0;
    checks++; if (sent !== 16) begin failures++; $display("FAIL bp_accepted: got %0d want 16", sent); end
    checks++; if (S_AXI_WREADY !== 1'b0) begin failures++; $display("FAIL bp_wready_full: got %0b want 0", S_AXI_WREADY); end
    checks++; if (M_AXI_WVALID !== 1'b1) begin failures++; $display("FAIL bp_wvalid_stalled: got %0b want 1", M_AXI_WVALID); end
    checks++; if (stable_ok !== 1'b1) begin failures++; $display("FAIL bp_payload_stable: got %0b want 1", stable_ok); end
    M_AXI_WREADY = 1'b1;
    repeat (20) step();
    checks++; if (mw_q.size() !== 16) begin failures++; $display("FAIL bp_w_count: got %0d want 16", mw_q.size()); end
    if (mw_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (mw_q[i].data !== DW'(32'hC0 + i)) begin failures++; $display("FAIL bp_w_data[%0d]: got %0h want %0h", i, mw_q[i].data, 32'hC0 + i); end
        checks++; if (mw_q[i].last !== (i == 15)) begin failures++; $display("FAIL bp_w_last[%0d]: got %0b want %0b", i, mw_q[i].last, (i == 15)); end
        checks++; if (mw_q[i].cyc !== mw_q[0].cyc + i) begin failures++; $display("FAIL bp_w_cycle[%0d]: got %0d want %0d", i, mw_q[i].cyc, mw_q[0].cyc + i); end
      end
    end
    checks++; if (S_AXI_WREADY !== 1'b1) begin failures++; $display("FAIL bp_wready_drained: got %0b want 1", S_AXI_WREADY); end
  endtask

  // Five AWLEN=0 AWs with W withheld; the fifth waits for a len slot
  task automatic test_outstanding();
    int   k;
    logic hs;
    clear_mon();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      S_AXI_AWVALID = (k < 5);
      set_aw(4'h4, 32'((k + 1) * 256), 8'd0);
      hs = S_AXI_AWVALID && S_AXI_AWREADY;
      step();
      if (hs) k++;
    end
    S_AXI_AWVALID = 1'b0;
    checks++; if (k !== 5) begin failures++; $display("FAIL out_aw_accepted: got %0d want 5", k); end
    checks++; if (maw_q.size() !== 4) begin failures++; $display("FAIL out_aw_issued: got %0d want 4", maw_q.size()); end
    checks++; if (M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL out_awvalid_blocked: got %0b want 0", M_AXI_AWVALID); end
    for (int i = 0; i < 5; i++) begin
      S_AXI_WVALID = 1'b1;
      S_AXI_WDATA  = DW'(32'hD0 + i);
      S_AXI_WSTRB  = '1;
      S_AXI_WLAST  = 1'b1;
      step();
    end
    S_AXI_WVALID = 1'b0;
    repeat (8) step();
    checks++; if (maw_q.size() !== 5) begin failures++; $display("FAIL out_aw_total: got %0d want 5", maw_q.size()); end
    checks++; if (mw_q.size() !== 5) begin failures++; $display("FAIL out_w_total: got %0d want 5", mw_q.size()); end
    if (maw_q.size() == 5 && mw_q.size() == 5) begin
      checks++; if (maw_q[4].addr !== 32'h500) begin failures++; $display("FAIL out_aw5_addr: got %0h want 500", maw_q[4].addr); end
      checks++; if (maw_q[4].cyc !== mw_q[0].cyc + 1) begin failures++; $display("FAIL out_aw5_cycle: got %0d want %0d", maw_q[4].cyc, mw_q[0].cyc + 1); end
      for (int i = 0; i < 5; i++) begin
        checks++; if (mw_q[i].data !== DW'(32'hD0 + i)) begin failures++; $display("FAIL out_w_data[%0d]: got %0h want %0h", i, mw_q[i].data, 32'hD0 + i); end
        checks++; if (mw_q[i].last !== 1'b1) begin failures++; $display("FAIL out_w_last[%0d]: got %0b want 1", i, mw_q[i].last); end
        checks++; if (mw_q[i].cyc !== mw_q[0].cyc + i) begin failures++; $display("FAIL out_w_cycle[%0d]: got %0d want %0d", i, mw_q[i].cyc, mw_q[0].cyc + i); end
      end
    end
  endtask

  // AWLEN=2 with upstream WLAST wrongly on beat 1
  task automatic test_framing();
    logic ee [3];
    clear_mon();
    ee[0] = 1'b0; ee[1] = 1'b0; ee[2] = CHK_EN;
    set_aw(4'h6, 32'h0000_6000, 8'd2);
    S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S_AXI_WVALID = 1'b1;
      S_AXI_WDATA  = DW'(32'hE0 + i);
      S_AXI_WSTRB  = '1;
      S_AXI_WLAST  = (i == 1);
      step();
    end
    S_AXI_WVALID = 1'b0;
    repeat (4) step();
    checks++; if (mw_q.size() !== 3) begin failures++; $display("FAIL frame_w_count: got %0d want 3", mw_q.size()); end
    if (mw_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (mw_q[i].last !== (i == 2)) begin failures++; $display("FAIL frame_w_last[%0d]: got %0b want %0b", i, mw_q[i].last, (i == 2)); end
        checks++; if (mw_q[i].err !== ee[i]) begin failures++; $display("FAIL frame_err_at_beat[%0d]: got %0b want %0b", i, mw_q[i].err, ee[i]); end
      end
    end
    checks++; if (ERR_WLAST !== CHK_EN) begin failures++; $display("FAIL frame_err_sticky: got %0b want %0b", ERR_WLAST, CHK_EN); end
  endtask

  // Reset during beat 2 of an AWLEN=7 burst, then a clean AWLEN=0 burst
  task automatic test_reset_mid_burst();
    clear_mon();
    set_aw(4'h7, 32'h0000_7000, 8'd7);
    S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S_AXI_WVALID = 1'b1;
      S_AXI_WDATA  = DW'(32'hF0 + i);
      S_AXI_WSTRB  = '1;
      S_AXI_WLAST  = 1'b0;
      step();
    end
    checks++; if (M_AXI_WDATA !== DW'(32'hF2)) begin failures++; $display("FAIL rmb_beat2_present: got %0h want f2", M_AXI_WDATA); end
    ARESET        = 1'b1;
    S_AXI_WVALID  = 1'b0;
    @(negedge ACLK);
    checks++; if (M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL rmb_awvalid: got %0b want 0", M_AXI_AWVALID); end
    checks++; if (M_AXI_WVALID !== 1'b0) begin failures++; $display("FAIL rmb_wvalid: got %0b want 0", M_AXI_WVALID); end
    checks++; if (S_AXI_WREADY !== 1'b0) begin failures++; $display("FAIL rmb_wready: got %0b want 0", S_AXI_WREADY); end
    checks++; if (ERR_WLAST !== 1'b0) begin failures++; $display("FAIL rmb_err_cleared: got %0b want 0", ERR_WLAST); end
    checks++; if (mw_q.size() !== 2) begin failures++; $display("FAIL rmb_beats_before_reset: got %0d want 2", mw_q.size()); end
    ARESET = 1'b0;
    @(negedge ACLK);
    clear_mon();
    set_aw(4'h8, 32'h0000_8000, 8'd0);
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_WDATA   = DW'(32'hF00);
    S_AXI_WSTRB   = 16'h00FF;
    S_AXI_WLAST   = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    repeat (5) step();
    checks++; if (maw_q.size() !== 1) begin failures++; $display("FAIL rmb_new_aw_count: got %0d want 1", maw_q.size()); end
    if (maw_q.size() == 1) begin
      checks++; if (maw_q[0].addr !== 32'h8000 || maw_q[0].cyc !== 1) begin failures++; $display("FAIL rmb_new_aw: got addr %0h cyc %0d want 8000 cyc 1", maw_q[0].addr, maw_q[0].cyc); end
    end
    checks++; if (mw_q.size() !== 1) begin failures++; $display("FAIL rmb_new_w_count: got %0d want 1", mw_q.size()); end
    if (mw_q.size() == 1) begin
      checks++; if (mw_q[0].data !== DW'(32'hF00)) begin failures++; $display("FAIL rmb_new_w_data: got %0h want f00", mw_q[0].data); end
      checks++; if (mw_q[0].last !== 1'b1) begin failures++; $display("FAIL rmb_new_w_last: got %0b want 1", mw_q[0].last); end
      checks++; if (mw_q[0].cyc !== 2) begin failures++; $display("FAIL rmb_new_w_cycle: got %0d want 2", mw_q[0].cyc); end
      checks++; if (mw_q[0].strb !== 16'h00FF) begin failures++; $display("FAIL rmb_new_w_strb: got %0h want ff", mw_q[0].strb); end
    end
    checks++; if (ERR_WLAST !== 1'b0) begin failures++; $display("FAIL rmb_new_err: got %0b want 0", ERR_WLAST); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    first_wv = -1;
    ARESET   = 1'b1;
    @(negedge ACLK);
    test_reset();
    test_single_burst();
    test_w_before_aw();
    test_backpressure();
    test_outstanding();
    test_framing();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
